serial_master_port: RTL and testbench
=====================================

Name: serial_master_port

Overview:
- Bus-side engine directly downstream of the event handler.
- Latches the handler's instruction, slave_select, address, data_out and burst_num, and serialises a header plus write data onto the serial bus.
- For reads, captures slave data words bit-serially.
- Returns tx_done, rx_done, new_rx, trans_done and data_in pulses so the handler can leave its WRITE/READ states.

Parameters:
- SLAVE_LEN, 2, slave select width.
- ADDR_LEN, 12, address width.
- DATA_LEN, 8, data word width.
- BURST_LEN, 12, burst count width.
- TIMEOUT, 64, idle cycles allowed per read bit before abort (must be at least 2).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- instruction  in  2  from handler; 00 idle, 10 write, 11 read, 01 ignored.
- slave_select  in  SLAVE_LEN  target slave.
- address  in  ADDR_LEN  start address.
- data_out  in  DATA_LEN  write word from handler.
- burst_num  in  BURST_LEN  word count; 0 is treated as 1.
- data_in  out  DATA_LEN  last received word, or all-ones on timeout.
- tx_done  out  1  one-cycle pulse at the last bit of each write word.
- rx_done  out  1  one-cycle pulse when a read word completes.
- new_rx  out  1  one-cycle pulse, identical timing to rx_done.
- trans_done  out  1  one-cycle pulse at the end of the transaction.
- timeout_err  out  1  one-cycle pulse on read abort.
- bus_valid  out  1  master is driving bus_tx.
- bus_tx  out  1  serial data out.
- bus_slave  out  SLAVE_LEN  latched slave select, held for the whole transaction.
- bus_rx  in  1  serial data from slave.
- bus_rx_valid  in  1  slave is driving bus_rx this cycle.

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0; counters cleared.
- States: IDLE, HEADER, WDATA, RWAIT, FINISH.
- IDLE → HEADER:
  - Triggered when instruction is 10 or 11.
  - Latches all input fields and words = (burst_num==0 ? 1 : burst_num).
  - Fields are never re-sampled mid-transaction.
- HEADER:
  - bus_valid=1, one bit per cycle, H = 2+ADDR_LEN+BURST_LEN bits (26 by default).
  - Bit order: instruction[1], instruction[0], then address LSB-first, then burst_num LSB-first.
  - The first bit is driven in the cycle after instruction is sampled.
- HEADER → WDATA (write):
  - DATA_LEN bits per word, LSB-first, bus_valid=1.
  - data_out is sampled at the first bit of each word.
  - tx_done pulses on the last bit of each word.
  - On the last word, trans_done pulses in the same cycle and the state goes to FINISH.
- HEADER → RWAIT (read):
  - bus_valid=0.
  - Each cycle with bus_rx_valid=1 shifts bus_rx into the word LSB-first; gap cycles are tolerated.
  - On the DATA_LEN-th bit, data_in updates on the same edge as the new_rx and rx_done pulses (the next cycle).
  - On the last word, trans_done pulses in that same cycle; the handler relies on new_rx and trans_done coinciding.
- Timeout:
  - The counter restarts on each valid bit.
  - After TIMEOUT consecutive cycles without bus_rx_valid: data_in = all-ones, and new_rx, rx_done, trans_done and timeout_err pulse together; go to FINISH.
- FINISH:
  - bus_valid=0; wait for instruction==00, then go to IDLE.
  - This prevents a stale instruction from restarting a transaction in the cycle trans_done is seen.
- Width rules:
  - The word counter is BURST_LEN wide; maximum 2^BURST_LEN−1 words.
  - The header bit counter holds H−1; the timeout counter is clog2(TIMEOUT+1) wide.
- bus_tx is 0 whenever bus_valid=0.
- Reset mid-transaction: bus_valid drops asynchronously and the transaction is discarded with no done pulses.

Decomposition:
- serial_bus_pkg:
  - instruction constants INSTR_IDLE=2'b00, INSTR_WRITE=2'b10, INSTR_READ=2'b11;
  - state enum;
  - header-length constant function.
- One sub-module, serial_shift_reg:
  - parameterised shift register with parallel load and serial shift-in;
  - instantiated for both header/data transmit and read capture.

Test Plan:
- Write, 1 word:
  - Stimulus: instruction=10, address=0x0A5, burst_num=1, data_out=0x3C.
  - bus_tx over 34 cycles = 1,0 / 1,0,1,0,0,1,0,1,0,0,0,0 / 1,0×11 / 0,0,1,1,1,1,0,0.
  - tx_done and trans_done pulse together on cycle 34; FINISH until instruction=00.
- Write burst:
  - Stimulus: burst_num=3.
  - 3 tx_done pulses, 8 cycles apart; one trans_done with the third; burst_num=0 behaves as 1.
- Read, 2 words:
  - Stimulus: instruction=11; slave sends 0xA5 then 0x5A, with a 3-cycle gap inside word 1.
  - new_rx/rx_done pulse twice, data_in=0xA5 then 0x5A; trans_done coincides with the second new_rx.
- Read timeout:
  - Stimulus: slave silent for 64 cycles after the header.
  - data_in=0xFF; new_rx, rx_done, trans_done and timeout_err pulse in the same cycle.
- Robustness:
  - instruction=01 is ignored; instruction held at 10 after trans_done does not restart.
  - reset=0 mid-HEADER: bus_valid=0 immediately and all outputs return to 0.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial master port.
// Holds the handler instruction codes, the engine state encoding and the
// header-length helper used to size the transmit path.
package serial_bus_pkg;

  localparam logic [1:0] INSTR_IDLE  = 2'b00;
  localparam logic [1:0] INSTR_WRITE = 2'b10;
  localparam logic [1:0] INSTR_READ  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_WDATA,
    ST_RWAIT,
    ST_FINISH
  } state_e;

  // Header = 2 instruction bits + address + burst count.
  function automatic int hdr_len(input int addr_len, input int burst_len);
    return 2 + addr_len + burst_len;
  endfunction

endpackage

// File: rtl/serial_master_port_if.sv
// Handler + serial bus signal bundle for the serial master port.
//   master modport : the port engine (drives done pulses and the bus)
//   slave modport  : the environment (handler requests, slave bus replies)
interface serial_master_port_if #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12
);
  // handler side
  logic [1:0]           instruction;
  logic [SLAVE_LEN-1:0] slave_select;
  logic [ADDR_LEN-1:0]  address;
  logic [DATA_LEN-1:0]  data_out;
  logic [BURST_LEN-1:0] burst_num;
  logic [DATA_LEN-1:0]  data_in;
  logic                 tx_done;
  logic                 rx_done;
  logic                 new_rx;
  logic                 trans_done;
  logic                 timeout_err;
  // serial bus side
  logic                 bus_valid;
  logic                 bus_tx;
  logic [SLAVE_LEN-1:0] bus_slave;
  logic                 bus_rx;
  logic                 bus_rx_valid;

  modport master (
    input  instruction, slave_select, address, data_out, burst_num,
           bus_rx, bus_rx_valid,
    output data_in, tx_done, rx_done, new_rx, trans_done, timeout_err,
           bus_valid, bus_tx, bus_slave
  );

  modport slave (
    output instruction, slave_select, address, data_out, burst_num,
           bus_rx, bus_rx_valid,
    input  data_in, tx_done, rx_done, new_rx, trans_done, timeout_err,
           bus_valid, bus_tx, bus_slave
  );
endinterface

// File: rtl/serial_shift_reg.sv
// Right-shifting register with parallel load and serial shift-in at the MSB.
// Transmit use: load a word, read bit 0, shift each cycle.
// Receive use: shift bits in at the MSB; after WIDTH shifts the first bit
// received sits in bit 0.
//   clk_i, reset_ni : clock, async active-low reset
//   load_i/load_val_i : parallel load (wins over shift)
//   shift_i/sin_i     : shift right, sin_i enters at the MSB
//   q_o               : register contents
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i)       sr_d = load_val_i;
    else if (shift_i) sr_d = {sin_i, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) sr_q <= '0;
    else           sr_q <= sr_d;
  end

  assign q_o = sr_q;
endmodule

// File: rtl/serial_master_port.sv
// Serial master port: takes one handler instruction (write/read), sends a
// header (instruction, address, burst count, all LSB-first) and then either
// streams write words out or captures read words bit-serially, pulsing the
// done strobes the handler waits on.
//   clk_i, reset_ni : clock, async active-low reset
//   bus             : serial_master_port_if.master (handler fields, done
//                     pulses, data_in, and the serial bus pins)
module serial_master_port
  import serial_bus_pkg::*;
#(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12,
  parameter int TIMEOUT   = 64
) (
  input logic                  clk_i,
  input logic                  reset_ni,
  serial_master_port_if.master bus
);
  localparam int H   = hdr_len(ADDR_LEN, BURST_LEN);
  localparam int TXW = (H > DATA_LEN) ? H : DATA_LEN;
  localparam int BCW = $clog2(TXW);
  localparam int TOW = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;   // header / data / rx bit index
  logic [BURST_LEN-1:0] words_q, words_d;       // words still to move
  logic [TOW-1:0]       to_cnt_q, to_cnt_d;     // consecutive idle read cycles
  logic                 rd_q, rd_d;
  logic [SLAVE_LEN-1:0] slave_q, slave_d;
  logic [DATA_LEN-1:0]  data_in_q, data_in_d;
  logic                 rx_pulse_q, rx_pulse_d;
  logic                 rd_end_q, rd_end_d;
  logic                 to_err_q, to_err_d;

  logic                 tx_load, tx_shift, tx_bit, valid, tx_done, wr_end;
  logic [TXW-1:0]       tx_load_val, tx_q;
  logic [DATA_LEN-1:0]  rx_q;
  logic                 rx_shift;

  serial_shift_reg #(.WIDTH(TXW)) u_tx (
    .clk_i(clk_i), .reset_ni(reset_ni), .load_i(tx_load), .load_val_i(tx_load_val),
    .shift_i(tx_shift), .sin_i(1'b0), .q_o(tx_q)
  );

  serial_shift_reg #(.WIDTH(DATA_LEN)) u_rx (
    .clk_i(clk_i), .reset_ni(reset_ni), .load_i(1'b0), .load_val_i('0),
    .shift_i(rx_shift), .sin_i(bus.bus_rx), .q_o(rx_q)
  );

  assign rx_shift = (state_q == ST_RWAIT) && bus.bus_rx_valid;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    words_d     = words_q;
    to_cnt_d    = to_cnt_q;
    rd_d        = rd_q;
    slave_d     = slave_q;
    data_in_d   = data_in_q;
    rx_pulse_d  = 1'b0;
    rd_end_d    = 1'b0;
    to_err_d    = 1'b0;
    tx_load     = 1'b0;
    tx_load_val = '0;
    tx_shift    = 1'b0;
    tx_bit      = 1'b0;
    valid       = 1'b0;
    tx_done     = 1'b0;
    wr_end      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.instruction == INSTR_WRITE || bus.instruction == INSTR_READ) begin
          state_d     = ST_HEADER;
          bit_cnt_d   = '0;
          rd_d        = (bus.instruction == INSTR_READ);
          slave_d     = bus.slave_select;
          words_d     = (bus.burst_num == '0) ? BURST_LEN'(1) : bus.burst_num;
          tx_load     = 1'b1;
          // bit 0 goes out first, so instruction[1] lands at the LSB
          tx_load_val = TXW'({bus.burst_num, bus.address,
                              bus.instruction[0], bus.instruction[1]});
        end
      end
      ST_HEADER: begin
        valid    = 1'b1;
        tx_bit   = tx_q[0];
        tx_shift = 1'b1;
        if (bit_cnt_q == BCW'(H - 1)) begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = rd_q ? ST_RWAIT : ST_WDATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      ST_WDATA: begin
        valid = 1'b1;
        // The handler refreshes data_out after seeing tx_done, so the word is
        // taken live on its first bit and the remainder parked in the shifter.
        if (bit_cnt_q == '0) begin
          tx_bit      = bus.data_out[0];
          tx_load     = 1'b1;
          tx_load_val = TXW'(bus.data_out >> 1);
        end else begin
          tx_bit   = tx_q[0];
          tx_shift = 1'b1;
        end
        if (bit_cnt_q == BCW'(DATA_LEN - 1)) begin
          tx_done   = 1'b1;
          bit_cnt_d = '0;
          if (words_q == BURST_LEN'(1)) begin
            wr_end  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            words_d = words_q - BURST_LEN'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      ST_RWAIT: begin
        if (bus.bus_rx_valid) begin
          to_cnt_d = '0;
          if (bit_cnt_q == BCW'(DATA_LEN - 1)) begin
            data_in_d  = {bus.bus_rx, rx_q[DATA_LEN-1:1]};
            rx_pulse_d = 1'b1;
            bit_cnt_d  = '0;
            if (words_q == BURST_LEN'(1)) begin
              rd_end_d = 1'b1;
              state_d  = ST_FINISH;
            end else begin
              words_d = words_q - BURST_LEN'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
          // slave went quiet: hand back all-ones and close the transaction
          data_in_d  = '1;
          rx_pulse_d = 1'b1;
          rd_end_d   = 1'b1;
          to_err_d   = 1'b1;
          state_d    = ST_FINISH;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      ST_FINISH: begin
        // hold until the handler drops its instruction, so a stale one
        // cannot start a second transaction
        if (bus.instruction == INSTR_IDLE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      words_q    <= '0;
      to_cnt_q   <= '0;
      rd_q       <= 1'b0;
      slave_q    <= '0;
      data_in_q  <= '0;
      rx_pulse_q <= 1'b0;
      rd_end_q   <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      words_q    <= words_d;
      to_cnt_q   <= to_cnt_d;
      rd_q       <= rd_d;
      slave_q    <= slave_d;
      data_in_q  <= data_in_d;
      rx_pulse_q <= rx_pulse_d;
      rd_end_q   <= rd_end_d;
      to_err_q   <= to_err_d;
    end
  end

  // Write-side strobes are combinational on the last bit; read-side strobes
  // are registered so they coincide with the data_in update.
  assign bus.bus_valid   = valid;
  assign bus.bus_tx      = valid & tx_bit;
  assign bus.bus_slave   = slave_q;
  assign bus.tx_done     = tx_done;
  assign bus.rx_done     = rx_pulse_q;
  assign bus.new_rx      = rx_pulse_q;
  assign bus.trans_done  = wr_end | rd_end_q;
  assign bus.timeout_err = to_err_q;
  assign bus.data_in     = data_in_q;

  logic unused_bits;
  assign unused_bits = ^{tx_q[TXW-1:1], rx_q[0]};
endmodule

// File: tb/tb_serial_master_port.sv
// Bench for serial_master_port: constant-vector table, directed corner
// sequences and randomized write/read transactions checked against a
// bit-stream model built from the header/data ordering rules.
module tb_serial_master_port;
  localparam int H       = 26;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_master_port_if ifc();
  serial_master_port dut (.clk_i(clk), .reset_ni(rst_n), .bus(ifc));

  int checks = 0;
  int failures = 0;

  logic [7:0] wdata [16];
  logic [7:0] rdata [16];
  int         gap   [128];

  logic       exp_pulse = 1'b0, exp_last = 1'b0, exp_to = 1'b0;
  logic [7:0] exp_pdata = 8'h00, exp_din = 8'h00;

  typedef struct {
    logic [1:0]  ins;
    logic [11:0] a;
    logic [11:0] bn;
    logic [1:0]  sl;
    logic [7:0]  d;
    int          e_valid;
    int          e_ones;
    int          e_txd;
    int          e_td;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic hdr_bit(input logic [1:0] ins, input logic [11:0] a,
                                   input logic [11:0] bn, input int c);
    if (c == 0) return ins[1];
    if (c == 1) return ins[0];
    if (c < 14) return a[c-2];
    return bn[c-14];
  endfunction

  task automatic start(input logic [1:0] ins, input logic [11:0] a,
                       input logic [11:0] bn, input logic [1:0] sl);
    ifc.instruction = ins; ifc.address = a; ifc.burst_num = bn;
    ifc.slave_select = sl; ifc.data_out = wdata[0];
    @(posedge clk); #1;
    // scramble fields: they must not be re-sampled
    ifc.address = ~a; ifc.burst_num = bn + 12'd7; ifc.slave_select = ~sl;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [11:0] bn, input logic [1:0] sl);
    int nw, total, w, b;
    logic eb;
    nw = (bn == 0) ? 1 : int'(bn);
    total = H + 8 * nw;
    start(2'b10, a, bn, sl);
    for (int c = 0; c < total; c++) begin
      w = 0; b = 0;
      if (c < H) begin
        eb = hdr_bit(2'b10, a, bn, c);
        ifc.data_out = 8'($urandom);
      end else begin
        w = (c - H) / 8; b = (c - H) % 8;
        eb = wdata[w][b];
        ifc.data_out = (b == 0) ? wdata[w] : 8'($urandom);
      end
      #1;
      chk("wr_valid", 32'(ifc.bus_valid), 32'd1);
      chk("wr_tx", 32'(ifc.bus_tx), 32'(eb));
      chk("wr_tx_done", 32'(ifc.tx_done), 32'(c >= H && b == 7));
      chk("wr_trans_done", 32'(ifc.trans_done), 32'(c == total - 1));
      chk("wr_slave", 32'(ifc.bus_slave), 32'(sl));
      chk("wr_rx_done", 32'(ifc.rx_done), 32'd0);
      chk("wr_data_in", 32'(ifc.data_in), 32'(exp_din));
      @(posedge clk); #1;
    end
    // instruction still 10: must not restart
    repeat (4) begin
      #1;
      chk("fin_valid", 32'(ifc.bus_valid), 32'd0);
      chk("fin_tx", 32'(ifc.bus_tx), 32'd0);
      chk("fin_trans_done", 32'(ifc.trans_done), 32'd0);
      chk("fin_tx_done", 32'(ifc.tx_done), 32'd0);
      @(posedge clk); #1;
    end
    ifc.instruction = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic rcycle(input logic v, input logic bv);
    ifc.bus_rx_valid = v;
    ifc.bus_rx = v ? bv : 1'($urandom_range(0, 1));
    #1;
    if (exp_pulse) exp_din = exp_pdata;
    chk("rd_new_rx", 32'(ifc.new_rx), 32'(exp_pulse));
    chk("rd_rx_done", 32'(ifc.rx_done), 32'(exp_pulse));
    chk("rd_trans_done", 32'(ifc.trans_done), 32'(exp_pulse && exp_last));
    chk("rd_timeout_err", 32'(ifc.timeout_err), 32'(exp_to));
    chk("rd_data_in", 32'(ifc.data_in), 32'(exp_din));
    chk("rd_valid", 32'(ifc.bus_valid), 32'd0);
    chk("rd_tx", 32'(ifc.bus_tx), 32'd0);
    chk("rd_tx_done", 32'(ifc.tx_done), 32'd0);
    exp_pulse = 1'b0; exp_last = 1'b0; exp_to = 1'b0;
    @(posedge clk); #1;
  endtask

  // nsend < 8*words leaves the slave silent afterwards and expects a timeout
  task automatic do_read(input logic [11:0] a, input logic [11:0] bn,
                         input logic [1:0] sl, input int nsend);
    int nw, w, b;
    nw = (bn == 0) ? 1 : int'(bn);
    ifc.bus_rx_valid = 1'b0; ifc.bus_rx = 1'b0;
    start(2'b11, a, bn, sl);
    for (int c = 0; c < H; c++) begin
      #1;
      chk("rh_valid", 32'(ifc.bus_valid), 32'd1);
      chk("rh_tx", 32'(ifc.bus_tx), 32'(hdr_bit(2'b11, a, bn, c)));
      chk("rh_slave", 32'(ifc.bus_slave), 32'(sl));
      @(posedge clk); #1;
    end
    for (int i = 0; i < nw * 8 && i < nsend; i++) begin
      w = i / 8; b = i % 8;
      repeat (gap[i]) rcycle(1'b0, 1'b0);
      rcycle(1'b1, rdata[w][b]);
      if (b == 7) begin
        exp_pulse = 1'b1; exp_pdata = rdata[w]; exp_last = (w == nw - 1);
      end
    end
    if (nsend < nw * 8) begin
      repeat (TIMEOUT) rcycle(1'b0, 1'b0);
      exp_pulse = 1'b1; exp_pdata = 8'hFF; exp_last = 1'b1; exp_to = 1'b1;
    end
    rcycle(1'b0, 1'b0);
    repeat (3) rcycle(1'b0, 1'b0);
    ifc.instruction = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    int nv, no, ntx, ntd, nsl, nw;
    logic [11:0] a, bn;
    logic [1:0]  sl;

    tbl[0] = '{2'b10, 12'h0A5, 12'd1, 2'b01, 8'h3C, 34, 10, 1, 1};
    tbl[1] = '{2'b10, 12'h000, 12'd0, 2'b10, 8'hFF, 34,  9, 1, 1};
    tbl[2] = '{2'b10, 12'hFFF, 12'd3, 2'b11, 8'h01, 50, 18, 3, 1};
    tbl[3] = '{2'b01, 12'h123, 12'd2, 2'b00, 8'h55,  0,  0, 0, 0};
    tbl[4] = '{2'b10, 12'h800, 12'd2, 2'b10, 8'h80, 42,  5, 2, 1};

    ifc.instruction = 2'b00; ifc.slave_select = '0; ifc.address = '0;
    ifc.data_out = '0; ifc.burst_num = '0; ifc.bus_rx = 1'b0; ifc.bus_rx_valid = 1'b0;
    for (int i = 0; i < 128; i++) gap[i] = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ifc.bus_valid), 32'd0);
    chk("rst_tx", 32'(ifc.bus_tx), 32'd0);
    chk("rst_slave", 32'(ifc.bus_slave), 32'd0);
    chk("rst_data_in", 32'(ifc.data_in), 32'd0);
    chk("rst_strobes", 32'({ifc.tx_done, ifc.rx_done, ifc.new_rx, ifc.trans_done, ifc.timeout_err}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // constant vector table (instruction held for the whole window)
    for (int v = 0; v < 5; v++) begin
      ifc.instruction = tbl[v].ins; ifc.address = tbl[v].a; ifc.burst_num = tbl[v].bn;
      ifc.slave_select = tbl[v].sl; ifc.data_out = tbl[v].d;
      nv = 0; no = 0; ntx = 0; ntd = 0; nsl = 0;
      repeat (80) begin
        @(posedge clk); #1;
        if (ifc.bus_valid) nv++;
        if (ifc.bus_tx) no++;
        if (ifc.tx_done) ntx++;
        if (ifc.trans_done) ntd++;
        if (ifc.bus_valid && ifc.bus_slave != tbl[v].sl) nsl++;
      end
      chk("tbl_valid_cycles", 32'(nv), 32'(tbl[v].e_valid));
      chk("tbl_ones", 32'(no), 32'(tbl[v].e_ones));
      chk("tbl_tx_done_cnt", 32'(ntx), 32'(tbl[v].e_txd));
      chk("tbl_trans_done_cnt", 32'(ntd), 32'(tbl[v].e_td));
      chk("tbl_slave_bad", 32'(nsl), 32'd0);
      ifc.instruction = 2'b00;
      @(posedge clk); #1;
    end

    // write 1 word, write burst of 3, burst 0 acting as 1
    wdata[0] = 8'h3C;
    do_write(12'h0A5, 12'd1, 2'b01);
    wdata[0] = 8'h11; wdata[1] = 8'hE7; wdata[2] = 8'h90;
    do_write(12'h3C3, 12'd3, 2'b10);
    wdata[0] = 8'hA6;
    do_write(12'h555, 12'd0, 2'b11);

    // read 2 words with a 3-cycle gap inside the first word
    rdata[0] = 8'hA5; rdata[1] = 8'h5A; gap[3] = 3;
    do_read(12'h0F0, 12'd2, 2'b01, 16);
    gap[3] = 0;

    // read timeout: slave silent after the header
    do_read(12'h00A, 12'd1, 2'b10, 0);

    // reset in the middle of the header
    wdata[0] = 8'h00;
    ifc.instruction = 2'b10; ifc.address = 12'hABC; ifc.burst_num = 12'd1; ifc.slave_select = 2'b11;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst_valid", 32'(ifc.bus_valid), 32'd1);
    rst_n = 1'b0; ifc.instruction = 2'b00;
    #1;
    chk("mid_rst_valid", 32'(ifc.bus_valid), 32'd0);
    chk("mid_rst_tx", 32'(ifc.bus_tx), 32'd0);
    chk("mid_rst_slave", 32'(ifc.bus_slave), 32'd0);
    chk("mid_rst_data_in", 32'(ifc.data_in), 32'd0);
    chk("mid_rst_strobes", 32'({ifc.tx_done, ifc.rx_done, ifc.new_rx, ifc.trans_done, ifc.timeout_err}), 32'd0);
    exp_din = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(ifc.bus_valid), 32'd0);
      chk("post_rst_trans_done", 32'(ifc.trans_done), 32'd0);
    end

    // randomized transactions
    for (int t = 0; t < 24; t++) begin
      a  = 12'($urandom);
      bn = 12'($urandom_range(0, 4));
      sl = 2'($urandom);
      nw = (bn == 0) ? 1 : int'(bn);
      for (int i = 0; i < 16; i++) begin
        wdata[i] = 8'($urandom);
        rdata[i] = 8'($urandom);
      end
      for (int i = 0; i < 128; i++)
        gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      if ($urandom_range(0, 1) == 1)
        do_write(a, bn, sl);
      else
        do_read(a, bn, sl, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nw * 8 - 1)) : nw * 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
